poly_eval_horner: RTL and testbench
===================================

# poly_eval_horner

- Parametrised polynomial evaluator: computes y = a_D·x^D + … + a_1·x + a_0 by Horner's method.
- Coefficients and x arrive serially on one data bus, each strobed by a Go press/release handshake.
- Computation uses one shared multiply/add datapath under a control FSM.
- Sits at the lab top level behind the switch/key inputs; generalises the fixed quadratic evaluator to any width and degree.

## Interface

Parameters:
- WIDTH, default 8: width of data, coefficients, x and result.
- DEGREE, default 2: polynomial degree D; D+1 coefficients. Legal range is 1..15.

Ports:
- Clock, input, 1: single clock; all state changes on the rising edge.
- Resetn, input, 1: reset is asynchronous and active-low.
- Go, input, 1: load strobe; a value is captured on a rising edge with Go=1; Go must return to 0 before the next capture.
- DataIn, input, WIDTH: coefficient or x value to capture.
- DataResult, output, WIDTH: last completed result; holds until the next completion.
- ResultValid, output, 1: high while DataResult holds a result that is complete and not yet superseded by a new load.
- Busy, output, 1: high during the MUL/ADD compute states.
- Overflow, output, 1: present only with POLY_EVAL_OVERFLOW_EN; see Configuration.

## Operation

- Storage: coefficient array coef[0..D], x register, accumulator acc, 4-bit index idx.
- Load order: a_D first, then down to a_0, then x.
- States and transitions:
  - LOAD_COEF: when Go=1, coef[idx] <= DataIn and go to LOAD_COEF_WAIT.
  - LOAD_COEF_WAIT: stay while Go=1. When Go=0: if idx=0, go to LOAD_X; otherwise idx <= idx-1 and go to LOAD_COEF.
  - LOAD_X: when Go=1, x <= DataIn and acc <= coef[D], then go to LOAD_X_WAIT.
  - LOAD_X_WAIT: stay while Go=1. When Go=0, idx <= D-1 and go to MUL.
  - MUL: acc <= acc·x, then go to ADD.
  - ADD: acc <= acc + coef[idx]. If idx=0: DataResult <= acc + coef[0] and go to DONE. Otherwise idx <= idx-1 and go to MUL.
  - DONE: ResultValid=1. When Go=1, coef[D] <= DataIn, idx <= D, ResultValid drops next cycle, and go to LOAD_COEF_WAIT.
- The index is reloaded with D on every new-set entry (reset, and capture in DONE). The first coef capture after reset occurs in LOAD_COEF with idx=D.
- Arithmetic is unsigned. Products and sums are truncated to the WIDTH LSBs (modulo 2^WIDTH).
- Go is ignored in MUL, ADD and *_WAIT states except for the Go=0 exit test. No capture occurs there.
- DataIn is sampled only at capture edges.

## Timing

- Reset (Resetn=0, asynchronous) puts the block in this state:
  - State LOAD_COEF, idx=D.
  - coef, x, acc all 0.
  - DataResult=0, ResultValid=0, Busy=0, Overflow=0.
- Reset deassertion is synchronised internally; the first capture can occur on the second rising edge after release.
- Latency: let W be the edge at which LOAD_X_WAIT samples Go=0.
  - MUL occupies cycle W..W+1.
  - DataResult updates and ResultValid rises at edge W+2·D.
  - Quadratic case (D=2): 4 cycles.
- Busy is high exactly for the 2·D cycles in MUL/ADD.
- Reset mid-compute aborts immediately. DataResult returns to 0 and no partial result appears.
- Go held high indefinitely parks the FSM in the current WAIT state with no further captures.
- Outputs are registered; there is no combinational path from Go or DataIn to any output.

## Configuration

- Macro POLY_EVAL_OVERFLOW_EN.
- Defined:
  - Overflow port exists.
  - Overflow is cleared at x capture.
  - Overflow is set (sticky) when any MUL has a nonzero upper WIDTH bits in its full 2·WIDTH product, or any ADD has a carry-out.
  - Overflow is valid with ResultValid and holds until the next x capture.
- Undefined: the Overflow port and its logic are absent; all other behaviour is identical.

## Test plan

- D=2, WIDTH=8: load 2, 3, 4, then x=5 with clean Go pulses. Required: DataResult=69 (0x45), ResultValid rises exactly 4 cycles after Go falls on x, Busy high for 4 cycles.
- D=2, macro defined: load 16, 0, 0, then x=16. Required: DataResult=0, Overflow=1. Next set 1, 1, 1 with x=2 gives DataResult=7, Overflow=0.
- D=3: load 1, 0, 0, 1, then x=3. Required: DataResult=28 after 6 compute cycles.
- Go held high for 10 cycles after a capture. Required: exactly one capture, state parked, then normal progress once Go=0.
- Pulse Resetn low during the second MUL. Required: all outputs 0 immediately; a following full load of 2, 3, 4 with x=5 yields 69.
- Back-to-back: in DONE with DataResult=69, press Go with DataIn=1. Required: ResultValid falls next cycle, DataResult stays 69 until the new result; then 0, 0, x=9 gives 81.

Source files
------------

// File: rtl/poly_eval_horner.sv
// poly_eval_horner: serially loaded polynomial evaluator (Horner's method) on one shared mul/add datapath.
// Optional sticky arithmetic overflow flag is built when POLY_EVAL_OVERFLOW_EN is defined.
//
// state          | meaning
// LOAD_COEF      | waiting for Go to capture coef[idx]
// LOAD_COEF_WAIT | coefficient captured, waiting for Go to drop
// LOAD_X         | waiting for Go to capture x (acc preloaded with coef[D])
// LOAD_X_WAIT    | x captured, waiting for Go to drop
// MUL            | acc <= acc * x
// ADD            | acc <= acc + coef[idx]; last ADD publishes the result
// DONE           | result valid; Go starts a new set with coef[D]
module poly_eval_horner #(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 2
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Go,
    input  logic [WIDTH-1:0] DataIn,
    output logic [WIDTH-1:0] DataResult,
    output logic             ResultValid,
    output logic             Busy
`ifdef POLY_EVAL_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    typedef enum logic [2:0] {
        LOAD_COEF      = 3'd0,
        LOAD_COEF_WAIT = 3'd1,
        LOAD_X         = 3'd2,
        LOAD_X_WAIT    = 3'd3,
        MUL            = 3'd4,
        ADD            = 3'd5,
        DONE           = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        ACC_HOLD = 2'd0,
        ACC_TOP  = 2'd1,
        ACC_MUL  = 2'd2,
        ACC_ADD  = 2'd3
    } acc_op_t;

    localparam logic [3:0] D_IDX = 4'(DEGREE);
    localparam logic [3:0] D_M1  = 4'(DEGREE - 1);

    if (DEGREE < 1 || DEGREE > 15) begin : g_bad_degree
        $error("poly_eval_horner: DEGREE must be in 1..15");
    end

    state_t           state_q, state_d;
    acc_op_t          acc_op;
    logic             rst_sync_n;
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       coef_waddr;
    logic             coef_we;
    logic             x_we;
    logic             result_we;
    logic [WIDTH-1:0] coef_q [16];
    logic [WIDTH-1:0] coef_sel;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mul_res;
    logic [WIDTH-1:0] add_res;

    // Assertion is immediate; release reaches the core one edge later.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) rst_sync_n <= 1'b0;
        else         rst_sync_n <= 1'b1;
    end

    assign coef_sel = coef_q[idx_q];

`ifdef POLY_EVAL_OVERFLOW_EN
    logic [2*WIDTH-1:0] prod_full;
    logic [WIDTH:0]     sum_full;
    logic               mul_ovf;
    logic               add_carry;

    assign prod_full = {{WIDTH{1'b0}}, acc_q} * {{WIDTH{1'b0}}, x_q};
    assign mul_res   = prod_full[WIDTH-1:0];
    assign mul_ovf   = |prod_full[2*WIDTH-1:WIDTH];
    assign sum_full  = {1'b0, acc_q} + {1'b0, coef_sel};
    assign add_res   = sum_full[WIDTH-1:0];
    assign add_carry = sum_full[WIDTH];
`else
    assign mul_res = acc_q * x_q;
    assign add_res = acc_q + coef_sel;
`endif

    always_ff @(posedge Clock or negedge rst_sync_n) begin
        if (!rst_sync_n) state_q <= LOAD_COEF;
        else             state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        coef_we    = 1'b0;
        coef_waddr = idx_q;
        x_we       = 1'b0;
        acc_op     = ACC_HOLD;
        result_we  = 1'b0;
        case (state_q)
            LOAD_COEF: begin
                if (Go) begin
                    coef_we = 1'b1;
                    state_d = LOAD_COEF_WAIT;
                end
            end
            LOAD_COEF_WAIT: begin
                if (!Go) begin
                    if (idx_q == 4'd0) begin
                        state_d = LOAD_X;
                    end else begin
                        idx_d   = idx_q - 4'd1;
                        state_d = LOAD_COEF;
                    end
                end
            end
            LOAD_X: begin
                if (Go) begin
                    x_we    = 1'b1;
                    acc_op  = ACC_TOP;
                    state_d = LOAD_X_WAIT;
                end
            end
            LOAD_X_WAIT: begin
                if (!Go) begin
                    idx_d   = D_M1;
                    state_d = MUL;
                end
            end
            MUL: begin
                acc_op  = ACC_MUL;
                state_d = ADD;
            end
            ADD: begin
                acc_op = ACC_ADD;
                if (idx_q == 4'd0) begin
                    result_we = 1'b1;
                    state_d   = DONE;
                end else begin
                    idx_d   = idx_q - 4'd1;
                    state_d = MUL;
                end
            end
            DONE: begin
                // Pressing Go here already carries a_D of the next set.
                if (Go) begin
                    coef_we    = 1'b1;
                    coef_waddr = D_IDX;
                    idx_d      = D_IDX;
                    state_d    = LOAD_COEF_WAIT;
                end
            end
            default: state_d = LOAD_COEF;
        endcase
    end

    always_ff @(posedge Clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            for (int i = 0; i < 16; i++) coef_q[i] <= '0;
            x_q         <= '0;
            acc_q       <= '0;
            idx_q       <= D_IDX;
            DataResult  <= '0;
            ResultValid <= 1'b0;
            Busy        <= 1'b0;
        end else begin
            idx_q <= idx_d;
            if (coef_we) coef_q[coef_waddr] <= DataIn;
            if (x_we)    x_q <= DataIn;
            case (acc_op)
                ACC_TOP: acc_q <= coef_q[D_IDX];
                ACC_MUL: acc_q <= mul_res;
                ACC_ADD: acc_q <= add_res;
                default: acc_q <= acc_q;
            endcase
            if (result_we) DataResult <= add_res;
            ResultValid <= (state_d == DONE);
            Busy        <= (state_d == MUL) || (state_d == ADD);
        end
    end

`ifdef POLY_EVAL_OVERFLOW_EN
    always_ff @(posedge Clock or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            Overflow <= 1'b0;
        end else if (x_we) begin
            Overflow <= 1'b0;
        end else if ((acc_op == ACC_MUL && mul_ovf) || (acc_op == ACC_ADD && add_carry)) begin
            Overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_poly_eval_horner.sv
// Testbench for poly_eval_horner: table vectors, multi-cycle corner sequences and random sets
// against a direct power-sum reference model (D=2 and D=3 instances, WIDTH=8).
module tb_poly_eval_horner;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       go2, go3;
    logic [7:0] din2, din3;
    logic [7:0] res2, res3;
    logic       rv2, rv3, busy2, busy3;
`ifdef POLY_EVAL_OVERFLOW_EN
    logic       ovf2, ovf3;
`endif

    always #5 Clock = ~Clock;

    poly_eval_horner #(.WIDTH(8), .DEGREE(2)) u_d2 (
        .Clock(Clock), .Resetn(Resetn), .Go(go2), .DataIn(din2),
        .DataResult(res2), .ResultValid(rv2), .Busy(busy2)
`ifdef POLY_EVAL_OVERFLOW_EN
        , .Overflow(ovf2)
`endif
    );

    poly_eval_horner #(.WIDTH(8), .DEGREE(3)) u_d3 (
        .Clock(Clock), .Resetn(Resetn), .Go(go3), .DataIn(din3),
        .DataResult(res3), .ResultValid(rv3), .Busy(busy3)
`ifdef POLY_EVAL_OVERFLOW_EN
        , .Overflow(ovf3)
`endif
    );

    typedef struct {
        int             d;
        logic [3:0][7:0] c;   // c[i] = a_i
        logic [7:0]     x;
        logic [7:0]     y;
        logic           ovf;
    } vec_t;

    vec_t       tbl [7];
    logic [7:0] cv [16];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         lat, bcnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic set_go(input int d, input logic v);
        if (d == 3) go3 = v; else go2 = v;
    endtask

    task automatic set_din(input int d, input logic [7:0] v);
        if (d == 3) din3 = v; else din2 = v;
    endtask

    function automatic logic [7:0] get_res(input int d);
        return (d == 3) ? res3 : res2;
    endfunction

    function automatic logic get_rv(input int d);
        return (d == 3) ? rv3 : rv2;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 3) ? busy3 : busy2;
    endfunction

`ifdef POLY_EVAL_OVERFLOW_EN
    function automatic logic get_ovf(input int d);
        return (d == 3) ? ovf3 : ovf2;
    endfunction

    // Overflow follows the Horner step sequence, tracked with wide integers.
    function automatic logic ref_ovf(input int d, input logic [7:0] c [16], input logic [7:0] x);
        longint a = c[d];
        logic   o = 1'b0;
        for (int i = d - 1; i >= 0; i--) begin
            longint p = a * x;
            if (p > 255) o = 1'b1;
            a = p % 256;
            a = a + c[i];
            if (a > 255) o = 1'b1;
            a = a % 256;
        end
        return o;
    endfunction
`endif

    // y = sum a_i * x^i mod 256, evaluated as a plain power series.
    function automatic logic [7:0] ref_eval(input int d, input logic [7:0] c [16], input logic [7:0] x);
        longint acc = 0;
        longint pw  = 1;
        for (int i = 0; i <= d; i++) begin
            acc = (acc + c[i] * pw) % 256;
            pw  = (pw * x) % 256;
        end
        return 8'(acc);
    endfunction

    // Go pulse held for 'hold' edges, then one edge with Go low so the WAIT state exits.
    task automatic press(input int d, input logic [7:0] v, input int hold);
        set_din(d, v);
        set_go(d, 1'b1);
        repeat (hold) tick();
        set_go(d, 1'b0);
        tick();
    endtask

    // Captures x, returns edges from W until ResultValid and the Busy samples seen meanwhile.
    task automatic finish_x(input int d, input logic [7:0] x, output int l, output int b);
        set_din(d, x);
        set_go(d, 1'b1);
        tick();
        set_go(d, 1'b0);
        tick();
        l = 0;
        b = 0;
        while (!get_rv(d) && l < 64) begin
            if (get_busy(d)) b++;
            tick();
            l++;
        end
        if (get_busy(d)) b++;
    endtask

    task automatic check_done(input string name, input int d, input logic [7:0] y,
                              input logic ovf, input int l, input int b);
        check({name, " result"}, get_res(d), y);
        check({name, " valid"}, get_rv(d), 1);
        check({name, " latency"}, l, 2 * d);
        check({name, " busy_cycles"}, b, 2 * d);
`ifdef POLY_EVAL_OVERFLOW_EN
        check({name, " overflow"}, get_ovf(d), ovf);
`else
        if (ovf === 1'bx) check({name, " ovf_model"}, 0, 1);
`endif
    endtask

    task automatic do_set(input string name, input int d, input logic [7:0] c [16],
                          input logic [7:0] x, input logic [7:0] y, input logic ovf);
        int l, b;
        for (int i = d; i >= 0; i--) press(d, c[i], 1);
        finish_x(d, x, l, b);
        check_done(name, d, y, ovf, l, b);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{d: 2, c: {8'd0, 8'd2,   8'd3,   8'd4},   x: 8'd5,   y: 8'd69,  ovf: 1'b0};
        tbl[1] = '{d: 2, c: {8'd0, 8'd16,  8'd0,   8'd0},   x: 8'd16,  y: 8'd0,   ovf: 1'b1};
        tbl[2] = '{d: 2, c: {8'd0, 8'd1,   8'd1,   8'd1},   x: 8'd2,   y: 8'd7,   ovf: 1'b0};
        tbl[3] = '{d: 2, c: {8'd0, 8'd255, 8'd255, 8'd255}, x: 8'd255, y: 8'd255, ovf: 1'b1};
        tbl[4] = '{d: 2, c: {8'd0, 8'd0,   8'd0,   8'd0},   x: 8'd7,   y: 8'd0,   ovf: 1'b0};
        tbl[5] = '{d: 3, c: {8'd1, 8'd0,   8'd0,   8'd1},   x: 8'd3,   y: 8'd28,  ovf: 1'b0};
        tbl[6] = '{d: 3, c: {8'd1, 8'd2,   8'd3,   8'd4},   x: 8'd0,   y: 8'd4,   ovf: 1'b0};

        Resetn = 1'b0;
        go2 = 1'b0; go3 = 1'b0; din2 = '0; din3 = '0;
        tick(); tick();
        check("reset result", res2, 0);
        check("reset valid", rv2, 0);
        check("reset busy", busy2, 0);
        check("reset result d3", res3, 0);
`ifdef POLY_EVAL_OVERFLOW_EN
        check("reset overflow", ovf2, 0);
`endif
        Resetn = 1'b1;
        tick(); tick(); tick();

        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < 16; i++) cv[i] = (i < 4) ? tbl[k].c[i] : 8'd0;
            do_set($sformatf("table[%0d]", k), tbl[k].d, cv, tbl[k].x, tbl[k].y, tbl[k].ovf);
        end

        // Back-to-back: new a_D pressed while DONE holds 69.
        for (int i = 0; i < 16; i++) cv[i] = 8'd0;
        cv[2] = 8'd2; cv[1] = 8'd3; cv[0] = 8'd4;
        do_set("b2b first", 2, cv, 8'd5, 8'd69, 1'b0);
        set_din(2, 8'd1);
        set_go(2, 1'b1);
        tick();
        check("b2b valid drop", rv2, 0);
        check("b2b result held", res2, 69);
        set_go(2, 1'b0);
        tick();
        press(2, 8'd0, 1);
        press(2, 8'd0, 1);
        check("b2b result before x", res2, 69);
        finish_x(2, 8'd9, lat, bcnt);
        check_done("b2b second", 2, 8'd81, 1'b0, lat, bcnt);

        // Go held for 10 edges with DataIn changed after the capture.
        set_din(2, 8'd2);
        set_go(2, 1'b1);
        tick();
        set_din(2, 8'd99);
        repeat (9) tick();
        check("hold valid", rv2, 0);
        check("hold busy", busy2, 0);
        set_go(2, 1'b0);
        tick();
        press(2, 8'd3, 1);
        press(2, 8'd4, 1);
        finish_x(2, 8'd5, lat, bcnt);
        check_done("hold", 2, 8'd69, 1'b0, lat, bcnt);

        // Reset pulse during the second MUL.
        press(2, 8'd2, 1);
        press(2, 8'd3, 1);
        press(2, 8'd4, 1);
        set_din(2, 8'd5);
        set_go(2, 1'b1);
        tick();
        set_go(2, 1'b0);
        tick(); tick(); tick();
        check("abort in mul busy", busy2, 1);
        Resetn = 1'b0;
        #1;
        check("abort result", res2, 0);
        check("abort valid", rv2, 0);
        check("abort busy", busy2, 0);
`ifdef POLY_EVAL_OVERFLOW_EN
        check("abort overflow", ovf2, 0);
`endif
        tick(); tick();
        Resetn = 1'b1;
        tick(); tick(); tick();
        check("abort stays clear", rv2, 0);
        do_set("after abort", 2, cv, 8'd5, 8'd69, 1'b0);

        // Random sets against the reference model.
        for (int n = 0; n < 24; n++) begin
            int         d;
            logic [7:0] x, y;
            logic       o;
            d = (n % 2 == 0) ? 2 : 3;
            for (int i = 0; i < 16; i++) cv[i] = (i <= d) ? 8'($urandom_range(0, 255)) : 8'd0;
            x = 8'($urandom_range(0, 255));
            y = ref_eval(d, cv, x);
`ifdef POLY_EVAL_OVERFLOW_EN
            o = ref_ovf(d, cv, x);
`else
            o = 1'b0;
`endif
            do_set($sformatf("random[%0d]", n), d, cv, x, y, o);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
